// File: rtl/gpsdc_host.sv
// Initiator for the GPSDC point/distance core: buffers points, strobes DEN, captures D/a for downstream.
// Optional WAIT_V watchdog is enabled with `define GPSDC_HOST_TIMEOUT_EN.
module gpsdc_host #(
  parameter int FIFO_DEPTH  = 4,
  parameter int DEN_GAP     = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_lon,
  input  logic [23:0] s_lat,
  output logic        DEN,
  output logic [23:0] LON_IN,
  output logic [23:0] LAT_IN,
  input  logic        Valid,
  input  logic [39:0] D,
  input  logic [63:0] a,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [39:0] r_d,
  output logic [63:0] r_a,
  output logic [15:0] r_idx,
  output logic        busy,
  output logic [1:0]  err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int GW = (DEN_GAP > 1) ? $clog2(DEN_GAP) : 1;
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(DEN_GAP - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_V, GAP} state_t;

  state_t        state_q, state_d;
  logic [47:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [23:0]   lon_q, lon_d, lat_q, lat_d;
  logic          r_valid_q, r_valid_d;
  logic [39:0]   r_d_q, r_d_d;
  logic [63:0]   r_a_q, r_a_d;
  logic [15:0]   r_idx_q, r_idx_d, idx_q, idx_d;
  logic          first_q, first_d;
  logic [1:0]    err_q, err_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          push, pop, slot_free;
  logic [47:0]   head;

`ifdef GPSDC_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // s_ready comes from the registered count only, so a pop never frees a slot in the same cycle.
  assign s_ready   = reset_n && (cnt_q != FULL_CNT);
  assign push      = s_valid && s_ready;
  assign pop       = (state_q == SEND);
  assign slot_free = !r_valid_q || r_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d     = cnt_q;
    lon_d     = lon_q;
    lat_d     = lat_q;
    r_valid_d = r_valid_q;
    r_d_d     = r_d_q;
    r_a_d     = r_a_q;
    r_idx_d   = r_idx_q;
    idx_d     = idx_q;
    first_d   = first_q;
    err_d     = err_q;
    gap_d     = gap_q;
`ifdef GPSDC_HOST_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    if (r_valid_q && r_ready) r_valid_d = 1'b0;
    if (Valid && (state_q != WAIT_V)) err_d[0] = 1'b1;

    unique case (state_q)
      IDLE: begin
        if ((cnt_q != '0) && slot_free) begin
          state_d = SEND;
          lon_d   = head[47:24];
          lat_d   = head[23:0];
        end
      end
      SEND: begin
        // The core has no partner for the very first point, so no result follows it.
        if (first_q) begin
          first_d = 1'b0;
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = WAIT_V;
`ifdef GPSDC_HOST_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      WAIT_V: begin
        if (Valid) begin
          r_valid_d = 1'b1;
          r_d_d     = D;
          r_a_d     = a;
          r_idx_d   = idx_q;
          idx_d     = idx_q + 16'd1;
          state_d   = GAP;
          gap_d     = GAP_LOAD;
        end
`ifdef GPSDC_HOST_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_d[1] = 1'b1;
          idx_d    = idx_q + 16'd1;
          state_d  = GAP;
          gap_d    = GAP_LOAD;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_lon, s_lat};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      lon_q     <= '0;
      lat_q     <= '0;
      r_valid_q <= 1'b0;
      r_d_q     <= '0;
      r_a_q     <= '0;
      r_idx_q   <= '0;
      idx_q     <= '0;
      first_q   <= 1'b1;
      err_q     <= '0;
      gap_q     <= '0;
`ifdef GPSDC_HOST_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      lon_q     <= lon_d;
      lat_q     <= lat_d;
      r_valid_q <= r_valid_d;
      r_d_q     <= r_d_d;
      r_a_q     <= r_a_d;
      r_idx_q   <= r_idx_d;
      idx_q     <= idx_d;
      first_q   <= first_d;
      err_q     <= err_d;
      gap_q     <= gap_d;
`ifdef GPSDC_HOST_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign DEN     = (state_q == SEND);
  assign LON_IN  = lon_q;
  assign LAT_IN  = lat_q;
  assign r_valid = r_valid_q;
  assign r_d     = r_d_q;
  assign r_a     = r_a_q;
  assign r_idx   = r_idx_q;
  assign busy    = (state_q != IDLE) || (cnt_q != '0);
  assign err     = err_q;

endmodule

// File: tb/tb_gpsdc_host.sv
// Scoreboard bench for gpsdc_host: driver pushes expected points/results, a negedge monitor pops and compares.
module tb_gpsdc_host;
  localparam int FIFO_DEPTH = 4;
  localparam int DEN_GAP    = 2;

  logic        clk = 1'b0;
  logic        reset_n, s_valid, s_ready, DEN, Valid, r_valid, r_ready, busy;
  logic [23:0] s_lon, s_lat, LON_IN, LAT_IN;
  logic [39:0] D, r_d;
  logic [63:0] a_c, r_a;
  logic [15:0] r_idx;
  logic [1:0]  err;

  gpsdc_host #(.FIFO_DEPTH(FIFO_DEPTH), .DEN_GAP(DEN_GAP), .TIMEOUT_CYC(1023)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_lon(s_lon), .s_lat(s_lat),
    .DEN(DEN), .LON_IN(LON_IN), .LAT_IN(LAT_IN),
    .Valid(Valid), .D(D), .a(a_c),
    .r_valid(r_valid), .r_ready(r_ready), .r_d(r_d), .r_a(r_a), .r_idx(r_idx),
    .busy(busy), .err(err)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [39:0] d; logic [63:0] a; logic [15:0] idx; } res_t;
  logic [47:0] exp_pts[$];
  res_t        exp_res[$];
  int          n_chk = 0, n_fail = 0;
  bit          core_auto = 0, core_first = 1, acc = 0;
  int          core_cnt = 0, tick_no = 0, den_seen = 0, last_den_tick = 0, prev_den_tick = 0;
  logic [15:0] exp_idx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic issue_valid(input logic [39:0] dv, input logic [63:0] av);
    res_t r;
    Valid = 1'b1; D = dv; a_c = av;
    r.d = dv; r.a = av; r.idx = exp_idx;
    exp_res.push_back(r);
    exp_idx++;
  endtask

  // One clock: record acceptance, advance, then let the core model react to DEN.
  task automatic cycle();
    #1;
    acc = reset_n && s_valid && s_ready;
    if (acc) exp_pts.push_back({s_lon, s_lat});
    @(posedge clk); #1;
    tick_no++;
    Valid = 1'b0;
    if (reset_n) begin
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) issue_valid(40'({$urandom(), $urandom()}), {$urandom(), $urandom()});
      end
      if (DEN) begin
        den_seen++;
        prev_den_tick = last_den_tick;
        last_den_tick = tick_no;
        if (core_first) core_first = 0;
        else if (core_auto) core_cnt = int'($urandom_range(1, 4));
      end
    end
  endtask

  task automatic push_pt(input logic [23:0] lon, input logic [23:0] lat);
    int k = 0;
    s_valid = 1'b1; s_lon = lon; s_lat = lat;
    do begin cycle(); k++; end while (!acc && k < 40);
    if (!acc) chk("push_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  task automatic wait_den(input int target);
    int k = 0;
    while (den_seen < target && k < 60) begin cycle(); k++; end
    if (den_seen < target) chk("den_timeout", 64'(den_seen), 64'(target));
  endtask

  task automatic drain();
    int k = 0;
    s_valid = 1'b0; r_ready = 1'b1;
    while (!(exp_pts.size() == 0 && exp_res.size() == 0 && !busy && !r_valid) && k < 400) begin
      cycle(); k++;
    end
    chk("drain_pts_left", 64'(exp_pts.size()), 0);
    chk("drain_res_left", 64'(exp_res.size()), 0);
  endtask

  // Monitor: compares DEN coordinates and accepted results against the scoreboard queues.
  initial begin
    logic [47:0] p;
    res_t        r;
    logic        hold = 0;
    logic [39:0] hd;
    logic [63:0] ha;
    logic [15:0] hi;
    int          cyc = 0, last = 0;
    bit          have_den = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin hold = 0; have_den = 0; continue; end
      if (hold) begin
        chk("r_hold_valid", 64'(r_valid), 1);
        chk("r_hold_data", {r_d, r_idx}, {hd, hi});
        chk("r_hold_a", r_a, ha);
      end
      if (DEN) begin
        chk("den_while_slot_busy", 64'(hold), 0);
        if (have_den) chk("den_min_spacing", 64'(cyc - last >= 2 + DEN_GAP), 1);
        have_den = 1; last = cyc;
        if (exp_pts.size() == 0) chk("den_unexpected", 1, 0);
        else begin
          p = exp_pts.pop_front();
          chk("lon_in", 64'(LON_IN), 64'(p[47:24]));
          chk("lat_in", 64'(LAT_IN), 64'(p[23:0]));
        end
      end
      if (r_valid && r_ready) begin
        if (exp_res.size() == 0) chk("result_unexpected", 1, 0);
        else begin
          r = exp_res.pop_front();
          chk("r_d", 64'(r_d), 64'(r.d));
          chk("r_a", r_a, r.a);
          chk("r_idx", 64'(r_idx), 64'(r.idx));
        end
      end
      hold = r_valid && !r_ready; hd = r_d; ha = r_a; hi = r_idx;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    reset_n = 0; s_valid = 0; s_lon = 0; s_lat = 0; Valid = 0; D = 0; a_c = 0; r_ready = 0;
    repeat (3) cycle();
    chk("rst_den", 64'(DEN), 0);
    chk("rst_s_ready", 64'(s_ready), 0);
    chk("rst_r_valid", 64'(r_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_coords", {LON_IN, LAT_IN}, 0);
    chk("rst_r_idx", 64'(r_idx), 0);
    reset_n = 1;
    cycle();

    // First point must skip WAIT_V: next DEN exactly 2+DEN_GAP later with no Valid.
    core_auto = 0;
    base = den_seen;
    push_pt(24'h01A2B3, 24'h004455);
    push_pt(24'h0ABCDE, 24'h012345);
    wait_den(base + 2);
    chk("first_skips_wait", 64'(last_den_tick - prev_den_tick), 64'(2 + DEN_GAP));

    // Directed result for the second point; hold with r_ready low.
    cycle();
    issue_valid(40'h00_0000_1234, 64'hDEAD_BEEF_0123_4567);
    r_ready = 0;
    cycle();
    chk("res_valid", 64'(r_valid), 1);
    chk("res_d", 64'(r_d), 64'h1234);
    chk("res_idx0", 64'(r_idx), 0);
    repeat (3) cycle();
    chk("res_held", 64'(r_valid), 1);

    // Result pending: FIFO fills to depth, no DEN, fifth point waits.
    base = den_seen;
    for (int i = 0; i < FIFO_DEPTH; i++) push_pt(24'($urandom()), 24'($urandom()));
    chk("fifo_full_s_ready", 64'(s_ready), 0);
    s_valid = 1; s_lon = 24'h55AA55; s_lat = 24'hAA55AA;
    repeat (6) cycle();
    chk("fifth_held", 64'(acc), 0);
    chk("no_den_while_pending", 64'(den_seen), 64'(base));
    core_auto = 1; r_ready = 1;
    for (int k = 0; k < 40 && !acc; k++) cycle();
    chk("fifth_accepted", 64'(acc), 1);
    s_valid = 0;
    drain();

    // Spurious Valid in GAP sets err[0] and produces no result.
    core_auto = 0;
    chk("err_before_spurious", 64'(err), 0);
    base = den_seen;
    push_pt(24'h123456, 24'h654321);
    wait_den(base + 1);
    cycle();
    issue_valid(40'h12_3456_789A, 64'h1111_2222_3333_4444);
    cycle();
    Valid = 1; D = 40'hFF_FFFF_FFFF; a_c = '1;
    cycle();
    cycle();
    chk("err_spurious", 64'(err), 1);
    drain();

    // Reset in WAIT_V abandons the exchange; first point afterwards skips WAIT_V again.
    base = den_seen;
    push_pt(24'h0F0F0F, 24'h070707);
    wait_den(base + 1);
    cycle(); cycle();
    reset_n = 0; r_ready = 0; s_valid = 0;
    exp_pts.delete(); exp_res.delete();
    core_first = 1; core_cnt = 0; exp_idx = 0;
    cycle();
    chk("wrst_den", 64'(DEN), 0);
    chk("wrst_r_valid", 64'(r_valid), 0);
    chk("wrst_s_ready", 64'(s_ready), 0);
    chk("wrst_busy", 64'(busy), 0);
    chk("wrst_err", 64'(err), 0);
    reset_n = 1; r_ready = 1;
    cycle();
    core_auto = 1;
    base = den_seen;
    push_pt(24'h000001, 24'h000002);
    push_pt(24'h000003, 24'h000004);
    wait_den(base + 2);
    chk("post_rst_first_skips", 64'(last_den_tick - prev_den_tick), 64'(2 + DEN_GAP));

    // Random traffic with random downstream back-pressure.
    for (int i = 0; i < 400; i++) begin
      if (!s_valid || acc) begin
        s_valid = ($urandom_range(0, 2) != 0);
        s_lon = 24'($urandom());
        s_lat = 24'($urandom());
      end
      r_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();
    chk("err_after_random", 64'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
